slow_sched: RTL and testbench

- Sequences the accelerator's fast/slow clock switch from the slow-access configuration bits and the slow-timeout field.
- On each new bus cycle to an enabled I/O class (IACK, VIA, IWM, SCC, SCSI, sound), it requests slow mode from the clock-switch unit over a req/ack handshake.
- Holds slow mode for SlowTimeout timebase ticks after the last qualifying access, then releases.
- Sits between the configuration register block and the clock-switch/gating logic.

---
 rtl/slow_sched_pkg.sv | 28 ++
 rtl/slow_sched_hold_cnt.sv | 47 ++++
 rtl/slow_sched.sv | 183 ++++++++++++++++++
 tb/tb_slow_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slow_sched_pkg.sv
// slow_sched_pkg
//   Shared definitions for the slow-clock scheduler: the scheduler state
//   encoding, the hold counter width, the power-on timeout value and the bit
//   positions of the I/O classes in the slow-access configuration bits.
package slow_sched_pkg;

  localparam int TO_W = 4;

  // Value the configuration register block presents on SlowTimeout after POR.
  localparam logic [TO_W-1:0] POR_TIMEOUT = 4'h3;

  // Bit order of the per-class select/enable vectors.
  localparam int CLS_IACK = 0;
  localparam int CLS_VIA  = 1;
  localparam int CLS_IWM  = 2;
  localparam int CLS_SCC  = 3;
  localparam int CLS_SCSI = 4;
  localparam int CLS_SND  = 5;
  localparam int NUM_CLS  = 6;

  typedef enum logic [1:0] {
    ST_FAST = 2'd0,
    ST_REQ  = 2'd1,
    ST_SLOW = 2'd2,
    ST_REL  = 2'd3
  } state_e;

endpackage

// File: rtl/slow_sched_hold_cnt.sv
// slow_hold_cnt
//   Loadable down-counter that times how long the CPU stays in slow mode.
//   A load always wins over a tick in the same cycle, and the counter stops
//   at zero instead of wrapping.
//   Ports:
//     clk, rst  - clock and asynchronous active-high reset
//     load      - load load_val (takes priority over tick)
//     load_val  - value to load
//     tick      - decrement by one when the count is nonzero
//     cnt       - current count
//     zero      - count is zero
module slow_hold_cnt #(
  parameter int TO_W = slow_sched_pkg::TO_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [TO_W-1:0] load_val,
  input  logic            tick,
  output logic [TO_W-1:0] cnt,
  output logic            zero
);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - TO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/slow_sched.sv
// slow_sched
//   Schedules the accelerator's fast/slow clock switch. A new bus cycle to an
//   I/O class whose slow enable is set requests slow mode from the clock-switch
//   unit (SlowReq/SlowAck level handshake), stalls the CPU cycle with BusHold
//   until the slow clock is confirmed, holds slow mode for SlowTimeout timebase
//   ticks after the last such access, and then releases.
//   Ports:
//     CLK, POR             - clock, asynchronous active-high reset
//     BACT                 - CPU bus cycle active
//     IACKCyc..SndCS       - per-class selects of the current cycle
//     SlowIACK..SlowSnd    - per-class slow enables
//     SlowClockGate        - master enable for slow scheduling
//     SlowTimeout          - hold length in TimerTick periods
//     TimerTick            - one-CLK timebase pulse
//     SlowAck              - clock-switch unit reports CPU running slow
//     SlowReq              - request slow clock
//     BusHold              - stall the CPU cycle until slow mode is confirmed
//     SlowActive           - slow mode granted and holding
//     HoldCnt              - current hold counter
module slow_sched #(
  parameter int TO_W = slow_sched_pkg::TO_W
) (
  input  logic            CLK,
  input  logic            POR,
  input  logic            BACT,
  input  logic            IACKCyc,
  input  logic            VIACS,
  input  logic            IWMCS,
  input  logic            SCCCS,
  input  logic            SCSICS,
  input  logic            SndCS,
  input  logic            SlowIACK,
  input  logic            SlowVIA,
  input  logic            SlowIWM,
  input  logic            SlowSCC,
  input  logic            SlowSCSI,
  input  logic            SlowSnd,
  input  logic            SlowClockGate,
  input  logic [TO_W-1:0] SlowTimeout,
  input  logic            TimerTick,
  input  logic            SlowAck,
  output logic            SlowReq,
  output logic            BusHold,
  output logic            SlowActive,
  output logic [TO_W-1:0] HoldCnt
);

  import slow_sched_pkg::*;

  logic [NUM_CLS-1:0] cls_sel;
  logic [NUM_CLS-1:0] cls_en;
  logic               start;
  logic               hit;

  state_e state_q, state_d;
  logic   bactr_q;
  logic   pend_q, pend_d;
  logic   slow_req_q, slow_req_d;
  logic   slow_active_q, slow_active_d;
  logic   bus_hold;
  logic   cnt_load;
  logic   cnt_tick;
  logic   cnt_zero;
  logic [TO_W-1:0] hold_cnt;

  always_comb begin
    cls_sel           = '0;
    cls_en            = '0;
    cls_sel[CLS_IACK] = IACKCyc;
    cls_sel[CLS_VIA]  = VIACS;
    cls_sel[CLS_IWM]  = IWMCS;
    cls_sel[CLS_SCC]  = SCCCS;
    cls_sel[CLS_SCSI] = SCSICS;
    cls_sel[CLS_SND]  = SndCS;
    cls_en[CLS_IACK]  = SlowIACK;
    cls_en[CLS_VIA]   = SlowVIA;
    cls_en[CLS_IWM]   = SlowIWM;
    cls_en[CLS_SCC]   = SlowSCC;
    cls_en[CLS_SCSI]  = SlowSCSI;
    cls_en[CLS_SND]   = SlowSnd;
  end

  // Only the first cycle of a bus cycle can qualify; the class is looked at
  // in that cycle alone.
  assign start = BACT & ~bactr_q;
  assign hit   = start & (|(cls_sel & cls_en)) & SlowClockGate;

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    bus_hold = 1'b0;
    cnt_load = 1'b0;
    cnt_tick = 1'b0;
    unique case (state_q)
      ST_FAST: begin
        if (hit) begin
          state_d  = ST_REQ;
          bus_hold = 1'b1;
        end
      end
      // An in-flight request is always completed, even if the gate fell;
      // in that case the grant is immediately released.
      ST_REQ: begin
        bus_hold = 1'b1;
        if (SlowAck) begin
          if (SlowClockGate) begin
            state_d  = ST_SLOW;
            cnt_load = 1'b1;
          end else begin
            state_d = ST_REL;
          end
        end
      end
      ST_SLOW: begin
        if (!SlowClockGate) begin
          state_d = ST_REL;
        end else if (hit) begin
          cnt_load = 1'b1;
        end else begin
          cnt_tick = TimerTick;
          if (cnt_zero && !BACT) begin
            state_d = ST_REL;
          end
        end
      end
      // A hit while the clock is still switching back is remembered and
      // re-requested once the unit reports fast again.
      ST_REL: begin
        if (!SlowClockGate) begin
          pend_d = 1'b0;
        end else if (hit) begin
          pend_d = 1'b1;
        end
        bus_hold = pend_d;
        if (!SlowAck) begin
          state_d = pend_d ? ST_REQ : ST_FAST;
          pend_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_FAST;
      end
    endcase
    slow_req_d    = (state_d == ST_REQ) || (state_d == ST_SLOW);
    slow_active_d = (state_d == ST_SLOW);
  end

  always_ff @(posedge CLK or posedge POR) begin
    if (POR) begin
      state_q       <= ST_FAST;
      bactr_q       <= 1'b0;
      pend_q        <= 1'b0;
      slow_req_q    <= 1'b0;
      slow_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bactr_q       <= BACT;
      pend_q        <= pend_d;
      slow_req_q    <= slow_req_d;
      slow_active_q <= slow_active_d;
    end
  end

  slow_hold_cnt #(
    .TO_W(TO_W)
  ) u_hold_cnt (
    .clk      (CLK),
    .rst      (POR),
    .load     (cnt_load),
    .load_val (SlowTimeout),
    .tick     (cnt_tick),
    .cnt      (hold_cnt),
    .zero     (cnt_zero)
  );

  // BusHold is combinational from the start cycle, so it must be forced low
  // while POR is asserted even if BACT is already high.
  assign BusHold    = bus_hold & ~POR;
  assign SlowReq    = slow_req_q;
  assign SlowActive = slow_active_q;
  assign HoldCnt    = hold_cnt;

endmodule

// File: tb/tb_slow_sched.sv
// tb_slow_sched
//   Self-checking bench for slow_sched: directed vector tables, hand-written
//   corner sequences and randomized traffic, all compared cycle by cycle
//   against a behavioural model of the scheduler.
module tb_slow_sched;

  localparam int IACK = 0;
  localparam int VIA  = 1;
  localparam int IWM  = 2;
  localparam int SCC  = 3;
  localparam int SCSI = 4;
  localparam int SND  = 5;

  localparam logic [5:0] M_VIA  = 6'b000010;
  localparam logic [5:0] M_IWM  = 6'b000100;
  localparam logic [5:0] M_SCC  = 6'b001000;
  localparam logic [5:0] M_SCSI = 6'b010000;

  typedef struct {
    logic       bact;
    logic [5:0] sel;
    logic [5:0] en;
    logic       gate;
    logic [3:0] tmo;
    logic       tick;
    logic       ack;
  } stim_t;

  typedef struct {
    logic       req;
    logic       hold;
    logic       act;
    logic [3:0] cnt;
  } resp_t;

  typedef struct {
    stim_t s;
    resp_t r;
  } vec_t;

  logic       CLK;
  logic       POR;
  logic       BACT;
  logic       IACKCyc, VIACS, IWMCS, SCCCS, SCSICS, SndCS;
  logic       SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd;
  logic       SlowClockGate;
  logic [3:0] SlowTimeout;
  logic       TimerTick;
  logic       SlowAck;
  logic       SlowReq;
  logic       BusHold;
  logic       SlowActive;
  logic [3:0] HoldCnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase kept as independent flags
  // (requesting / granted / draining back to fast).
  bit         m_req, m_active, m_draining, m_pend, m_prev_bact;
  logic [3:0] m_cnt;
  bit         n_req, n_active, n_draining, n_pend, n_prev_bact;
  logic [3:0] n_cnt;

  slow_sched #(
    .TO_W(4)
  ) dut (
    .CLK           (CLK),
    .POR           (POR),
    .BACT          (BACT),
    .IACKCyc       (IACKCyc),
    .VIACS         (VIACS),
    .IWMCS         (IWMCS),
    .SCCCS         (SCCCS),
    .SCSICS        (SCSICS),
    .SndCS         (SndCS),
    .SlowIACK      (SlowIACK),
    .SlowVIA       (SlowVIA),
    .SlowIWM       (SlowIWM),
    .SlowSCC       (SlowSCC),
    .SlowSCSI      (SlowSCSI),
    .SlowSnd       (SlowSnd),
    .SlowClockGate (SlowClockGate),
    .SlowTimeout   (SlowTimeout),
    .TimerTick     (TimerTick),
    .SlowAck       (SlowAck),
    .SlowReq       (SlowReq),
    .BusHold       (BusHold),
    .SlowActive    (SlowActive),
    .HoldCnt       (HoldCnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic stim_t S(input logic bact, input logic [5:0] sel, input logic [5:0] en,
                              input logic gate, input logic [3:0] tmo, input logic tick,
                              input logic ack);
    stim_t s;
    s.bact = bact; s.sel = sel; s.en = en; s.gate = gate;
    s.tmo = tmo; s.tick = tick; s.ack = ack;
    return s;
  endfunction

  function automatic resp_t R(input logic req, input logic hold, input logic act,
                              input logic [3:0] cnt);
    resp_t r;
    r.req = req; r.hold = hold; r.act = act; r.cnt = cnt;
    return r;
  endfunction

  // Drives one cycle's worth of inputs.
  task automatic applyStimulus(input stim_t s);
    BACT          = s.bact;
    IACKCyc       = s.sel[IACK];
    VIACS         = s.sel[VIA];
    IWMCS         = s.sel[IWM];
    SCCCS         = s.sel[SCC];
    SCSICS        = s.sel[SCSI];
    SndCS         = s.sel[SND];
    SlowIACK      = s.en[IACK];
    SlowVIA       = s.en[VIA];
    SlowIWM       = s.en[IWM];
    SlowSCC       = s.en[SCC];
    SlowSCSI      = s.en[SCSI];
    SlowSnd       = s.en[SND];
    SlowClockGate = s.gate;
    SlowTimeout   = s.tmo;
    TimerTick     = s.tick;
    SlowAck       = s.ack;
  endtask

  // Compares all four outputs against an expectation.
  task automatic checkOutput(input string tag, input resp_t e);
    checks++;
    if (SlowReq !== e.req) begin
      errors++;
      $display("[TB] FAIL %s SlowReq got %b want %b (t=%0t)", tag, SlowReq, e.req, $time);
    end
    checks++;
    if (BusHold !== e.hold) begin
      errors++;
      $display("[TB] FAIL %s BusHold got %b want %b (t=%0t)", tag, BusHold, e.hold, $time);
    end
    checks++;
    if (SlowActive !== e.act) begin
      errors++;
      $display("[TB] FAIL %s SlowActive got %b want %b (t=%0t)", tag, SlowActive, e.act, $time);
    end
    checks++;
    if (HoldCnt !== e.cnt) begin
      errors++;
      $display("[TB] FAIL %s HoldCnt got %0d want %0d (t=%0t)", tag, HoldCnt, e.cnt, $time);
    end
  endtask

  task automatic modelReset();
    m_req = 0; m_active = 0; m_draining = 0; m_pend = 0; m_prev_bact = 0; m_cnt = '0;
  endtask

  // Expected outputs for the current cycle plus the model's next state.
  task automatic modelEval(input stim_t s, output resp_t e);
    bit cls, hit, pend_now;
    cls = 0;
    for (int i = 0; i < 6; i++) cls = cls | (s.sel[i] & s.en[i]);
    hit = s.bact && !m_prev_bact && cls && s.gate;
    e = R(m_req, 1'b0, m_active, m_cnt);
    n_req = m_req; n_active = m_active; n_draining = m_draining;
    n_pend = m_pend; n_cnt = m_cnt; n_prev_bact = s.bact;
    if (m_draining) begin
      pend_now = s.gate && (m_pend || hit);
      e.hold = pend_now;
      n_pend = pend_now;
      if (!s.ack) begin
        n_draining = 0;
        n_pend = 0;
        n_req = pend_now;
      end
    end else if (m_active) begin
      if (!s.gate) begin
        n_active = 0; n_req = 0; n_draining = 1;
      end else if (hit) begin
        n_cnt = s.tmo;
      end else begin
        if (s.tick && m_cnt > 0) n_cnt = m_cnt - 4'd1;
        if (m_cnt == 0 && !s.bact) begin
          n_active = 0; n_req = 0; n_draining = 1;
        end
      end
    end else if (m_req) begin
      e.hold = 1;
      if (s.ack) begin
        if (s.gate) begin
          n_active = 1; n_cnt = s.tmo;
        end else begin
          n_req = 0; n_draining = 1;
        end
      end
    end else if (hit) begin
      e.hold = 1;
      n_req = 1;
    end
  endtask

  task automatic modelCommit();
    m_req = n_req; m_active = n_active; m_draining = n_draining;
    m_pend = n_pend; m_cnt = n_cnt; m_prev_bact = n_prev_bact;
  endtask

  // One clock cycle: drive, sample mid-cycle against the model (and the
  // table expectation when given), then advance the model on the edge.
  task automatic doCycle(input stim_t s, input bit use_tab, input resp_t tab, input string tag);
    resp_t me;
    applyStimulus(s);
    @(negedge CLK);
    modelEval(s, me);
    checkOutput({tag, "/model"}, me);
    if (use_tab) checkOutput(tag, tab);
    @(posedge CLK);
    modelCommit();
    #1;
  endtask

  vec_t  tab[$];
  bit    ack_lvl;
  int    ack_dly;
  logic  r_bact, r_gate;
  logic [5:0] r_sel, r_en;
  logic [3:0] r_tmo;

  initial begin
    POR = 1'b1;
    applyStimulus(S(0, 6'h00, 6'h00, 0, 4'd0, 0, 0));
    modelReset();
    #2;
    checkOutput("reset", R(0, 0, 0, 4'd0));
    @(posedge CLK);
    @(posedge CLK);
    #1;
    POR = 1'b0;

    // VIA access, timeout 3, ack two cycles after request
    tab.push_back('{S(0, 6'h00, M_VIA, 1, 4'd3, 0, 0), R(0, 0, 0, 4'd0)});
    tab.push_back('{S(1, M_VIA, M_VIA, 1, 4'd3, 0, 0), R(0, 1, 0, 4'd0)});
    tab.push_back('{S(1, M_VIA, M_VIA, 1, 4'd3, 0, 0), R(1, 1, 0, 4'd0)});
    tab.push_back('{S(1, M_VIA, M_VIA, 1, 4'd3, 0, 0), R(1, 1, 0, 4'd0)});
    tab.push_back('{S(1, M_VIA, M_VIA, 1, 4'd3, 0, 1), R(1, 1, 0, 4'd0)});
    tab.push_back('{S(1, M_VIA, M_VIA, 1, 4'd3, 1, 1), R(1, 0, 1, 4'd3)});
    tab.push_back('{S(0, 6'h00, M_VIA, 1, 4'd3, 1, 1), R(1, 0, 1, 4'd2)});
    tab.push_back('{S(0, 6'h00, M_VIA, 1, 4'd3, 0, 1), R(1, 0, 1, 4'd1)});
    tab.push_back('{S(0, 6'h00, M_VIA, 1, 4'd3, 1, 1), R(1, 0, 1, 4'd1)});
    tab.push_back('{S(1, 6'h00, M_VIA, 1, 4'd3, 0, 1), R(1, 0, 1, 4'd0)});
    tab.push_back('{S(0, 6'h00, M_VIA, 1, 4'd3, 0, 1), R(1, 0, 1, 4'd0)});
    tab.push_back('{S(0, 6'h00, M_VIA, 1, 4'd3, 0, 1), R(0, 0, 0, 4'd0)});
    tab.push_back('{S(0, 6'h00, M_VIA, 1, 4'd3, 0, 0), R(0, 0, 0, 4'd0)});
    tab.push_back('{S(0, 6'h00, M_VIA, 1, 4'd3, 0, 0), R(0, 0, 0, 4'd0)});
    // SCC disabled, then gate off: nothing may happen
    tab.push_back('{S(0, 6'h00, 6'b110111, 1, 4'd3, 0, 0), R(0, 0, 0, 4'd0)});
    tab.push_back('{S(1, M_SCC, 6'b110111, 1, 4'd3, 0, 0), R(0, 0, 0, 4'd0)});
    tab.push_back('{S(1, M_SCC, 6'b110111, 1, 4'd3, 1, 0), R(0, 0, 0, 4'd0)});
    tab.push_back('{S(0, 6'h00, 6'b110111, 1, 4'd3, 0, 0), R(0, 0, 0, 4'd0)});
    tab.push_back('{S(1, M_VIA, 6'h3F, 0, 4'd3, 0, 0), R(0, 0, 0, 4'd0)});
    tab.push_back('{S(1, M_VIA, 6'h3F, 0, 4'd3, 0, 0), R(0, 0, 0, 4'd0)});
    tab.push_back('{S(0, 6'h00, 6'h3F, 0, 4'd3, 0, 0), R(0, 0, 0, 4'd0)});
    foreach (tab[i]) doCycle(tab[i].s, 1, tab[i].r, $sformatf("tab%0d", i));

    // Reload beats tick in the same cycle
    doCycle(S(1, M_IWM, M_IWM, 1, 4'd1, 0, 0), 1, R(0, 1, 0, 4'd0), "rl_hit");
    doCycle(S(1, M_IWM, M_IWM, 1, 4'd1, 0, 0), 1, R(1, 1, 0, 4'd0), "rl_req");
    doCycle(S(1, M_IWM, M_IWM, 1, 4'd1, 0, 1), 1, R(1, 1, 0, 4'd0), "rl_ack");
    doCycle(S(0, 6'h00, M_IWM, 1, 4'd1, 0, 1), 1, R(1, 0, 1, 4'd1), "rl_slow");
    doCycle(S(1, M_IWM, M_IWM, 1, 4'd5, 1, 1), 1, R(1, 0, 1, 4'd1), "rl_both");
    doCycle(S(1, M_IWM, M_IWM, 1, 4'd5, 0, 1), 1, R(1, 0, 1, 4'd5), "rl_after");
    for (int k = 0; k < 5; k++)
      doCycle(S(0, 6'h00, M_IWM, 1, 4'd5, 1, 1), 1, R(1, 0, 1, 4'(5 - k)), $sformatf("rl_dn%0d", k));

    // Hit while draining: pend, BusHold, re-request
    doCycle(S(0, 6'h00, M_IWM, 1, 4'd5, 0, 1), 1, R(1, 0, 1, 4'd0), "pd_leave");
    doCycle(S(1, M_IWM, M_IWM, 1, 4'd5, 0, 1), 1, R(0, 1, 0, 4'd0), "pd_hit");
    doCycle(S(1, M_IWM, M_IWM, 1, 4'd5, 0, 1), 1, R(0, 1, 0, 4'd0), "pd_wait");
    doCycle(S(1, M_IWM, M_IWM, 1, 4'd5, 0, 0), 1, R(0, 1, 0, 4'd0), "pd_ackfall");
    doCycle(S(1, M_IWM, M_IWM, 1, 4'd5, 0, 0), 1, R(1, 1, 0, 4'd0), "pd_rereq");
    doCycle(S(1, M_IWM, M_IWM, 1, 4'd5, 0, 1), 1, R(1, 1, 0, 4'd0), "pd_ack");
    doCycle(S(0, 6'h00, M_IWM, 0, 4'd5, 0, 1), 1, R(1, 0, 1, 4'd5), "gt_drop");
    doCycle(S(0, 6'h00, M_IWM, 0, 4'd5, 1, 1), 1, R(0, 0, 0, 4'd5), "gt_rel");
    doCycle(S(0, 6'h00, M_IWM, 0, 4'd5, 0, 0), 1, R(0, 0, 0, 4'd5), "gt_ackfall");
    doCycle(S(0, 6'h00, M_IWM, 1, 4'd5, 0, 0), 1, R(0, 0, 0, 4'd5), "gt_fast");

    // Timeout 0 with a 4-cycle SCSI access
    doCycle(S(1, M_SCSI, M_SCSI, 1, 4'd0, 0, 0), 1, R(0, 1, 0, 4'd5), "z_hit");
    doCycle(S(1, M_SCSI, M_SCSI, 1, 4'd0, 0, 0), 1, R(1, 1, 0, 4'd5), "z_req");
    doCycle(S(1, M_SCSI, M_SCSI, 1, 4'd0, 0, 1), 1, R(1, 1, 0, 4'd5), "z_ack");
    doCycle(S(1, M_SCSI, M_SCSI, 1, 4'd0, 1, 1), 1, R(1, 0, 1, 4'd0), "z_busy");
    doCycle(S(0, 6'h00, M_SCSI, 1, 4'd0, 0, 1), 1, R(1, 0, 1, 4'd0), "z_idle");
    doCycle(S(0, 6'h00, M_SCSI, 1, 4'd0, 0, 1), 1, R(0, 0, 0, 4'd0), "z_rel");
    doCycle(S(0, 6'h00, M_SCSI, 1, 4'd0, 0, 0), 1, R(0, 0, 0, 4'd0), "z_ackfall");
    doCycle(S(0, 6'h00, M_SCSI, 1, 4'd0, 0, 0), 1, R(0, 0, 0, 4'd0), "z_fast");

    // POR in the middle of a request
    doCycle(S(1, M_VIA, M_VIA, 1, 4'd3, 0, 0), 1, R(0, 1, 0, 4'd0), "por_hit");
    applyStimulus(S(1, M_VIA, M_VIA, 1, 4'd3, 0, 0));
    #2;
    checkOutput("por_pre", R(1, 1, 0, 4'd0));
    POR = 1'b1;
    #1;
    checkOutput("por_now", R(0, 0, 0, 4'd0));
    modelReset();
    @(posedge CLK);
    #1;
    applyStimulus(S(0, 6'h00, M_VIA, 1, 4'd3, 0, 0));
    @(posedge CLK);
    #1;
    POR = 1'b0;
    doCycle(S(0, 6'h00, M_VIA, 1, 4'd3, 0, 0), 1, R(0, 0, 0, 4'd0), "por_idle");
    doCycle(S(1, M_VIA, M_VIA, 1, 4'd3, 0, 0), 1, R(0, 1, 0, 4'd0), "por_rehit");
    doCycle(S(1, M_VIA, M_VIA, 1, 4'd3, 0, 1), 1, R(1, 1, 0, 4'd0), "por_req");
    doCycle(S(0, 6'h00, M_VIA, 0, 4'd3, 0, 1), 1, R(1, 0, 1, 4'd3), "por_slow");
    doCycle(S(0, 6'h00, M_VIA, 1, 4'd3, 0, 0), 1, R(0, 0, 0, 4'd3), "por_rel");

    // Randomized traffic with a clock-switch unit that acks after 0..3 cycles
    ack_lvl = 0; ack_dly = 0;
    r_bact = 0; r_gate = 1; r_sel = '0; r_en = 6'h3F; r_tmo = 4'd2;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) r_bact = ~r_bact;
      r_sel = r_bact ? ((r_sel != '0) ? r_sel : 6'(1 << $urandom_range(0, 6))) : 6'h00;
      if ($urandom_range(0, 49) == 0) r_en = 6'($urandom);
      if ($urandom_range(0, 29) == 0) r_gate = ~r_gate;
      if ($urandom_range(0, 15) == 0) r_tmo = 4'($urandom_range(0, 7));
      if (SlowReq !== ack_lvl) begin
        if (ack_dly == 0) begin
          ack_lvl = SlowReq;
          ack_dly = $urandom_range(0, 3);
        end else begin
          ack_dly--;
        end
      end
      doCycle(S(r_bact, r_sel, r_en, r_gate, r_tmo, ($urandom_range(0, 3) == 0), ack_lvl),
              0, R(0, 0, 0, 4'd0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
